// File: rtl/cpu_mem_axi_wbuf.sv
// cpu_mem_axi_wbuf: CPU memory port to AXI4 bridge with a posted write buffer.
// Writes are pushed into a WB_DEPTH-entry FIFO and drained one entry at a time
// over AW/W; reads are held off until every buffered write has been answered on B.
// Optional performance counters are built when CPU_MEM_PERF_CNT_EN is defined;
// otherwise the counter outputs are tied to zero.
//
// Handshake rule for every channel: a transfer happens on the rising cpu_clk edge
// where valid and ready are both high; a source never drops valid or changes its
// payload before that edge, and ready may depend combinationally on valid.
module cpu_mem_axi_wbuf #(
  parameter int WB_DEPTH = 4,
  parameter int CNT_W    = 32
) (
  input  logic             cpu_clk,
  input  logic             cpu_reset,
  // CPU side
  input  logic [31:0]      Address,
  input  logic             MemWrite,
  input  logic [31:0]      Write_data,
  input  logic [3:0]       Write_strb,
  input  logic             MemRead,
  output logic             Mem_Req_Ready,
  output logic [31:0]      Read_data,
  output logic             Read_data_Valid,
  input  logic             Read_data_Ready,
  // AXI AR
  output logic [31:0]      cpu_mem_araddr,
  output logic             cpu_mem_arvalid,
  input  logic             cpu_mem_arready,
  output logic [2:0]       cpu_mem_arsize,
  output logic [1:0]       cpu_mem_arburst,
  output logic [7:0]       cpu_mem_arlen,
  // AXI R
  input  logic [31:0]      cpu_mem_rdata,
  input  logic             cpu_mem_rvalid,
  input  logic             cpu_mem_rlast,
  output logic             cpu_mem_rready,
  // AXI AW
  output logic [31:0]      cpu_mem_awaddr,
  output logic             cpu_mem_awvalid,
  input  logic             cpu_mem_awready,
  output logic [2:0]       cpu_mem_awsize,
  output logic [1:0]       cpu_mem_awburst,
  output logic [7:0]       cpu_mem_awlen,
  // AXI W
  output logic [31:0]      cpu_mem_wdata,
  output logic [3:0]       cpu_mem_wstrb,
  output logic             cpu_mem_wvalid,
  output logic             cpu_mem_wlast,
  input  logic             cpu_mem_wready,
  // AXI B
  input  logic             cpu_mem_bvalid,
  input  logic [1:0]       cpu_mem_bresp,
  output logic             cpu_mem_bready,
  // status
  output logic             wr_err,
  output logic [CNT_W-1:0] wb_full_stall_cnt,
  output logic [CNT_W-1:0] rd_drain_stall_cnt
);

  localparam int PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int OCC_W = $clog2(WB_DEPTH + 1);
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(WB_DEPTH);

  // buffer storage and bookkeeping
  logic [31:0]      fifo_addr [WB_DEPTH];
  logic [31:0]      fifo_data [WB_DEPTH];
  logic [3:0]       fifo_strb [WB_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic [OCC_W-1:0] ob_cnt;

  // head-of-buffer transfer tracking
  logic head_vld;
  logic aw_done;
  logic w_done;

  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic aw_hs;
  logic w_hs;
  logic aw_done_n;
  logic w_done_n;
  logic drained;
  logic unused_rlast;

  // Single-beat INCR transfers of one 32-bit word; B is always accepted.
  assign cpu_mem_arsize  = 3'b010;
  assign cpu_mem_awsize  = 3'b010;
  assign cpu_mem_arburst = 2'b01;
  assign cpu_mem_awburst = 2'b01;
  assign cpu_mem_arlen   = 8'd0;
  assign cpu_mem_awlen   = 8'd0;
  assign cpu_mem_wlast   = cpu_mem_wvalid;
  assign cpu_mem_bready  = 1'b1;

  // Every read is a single beat, so rlast carries no extra information.
  assign unused_rlast = cpu_mem_rlast;

  // Full is taken from the registered occupancy, so a same-cycle pop never frees a slot early.
  assign fifo_full  = (occ == DEPTH_OCC);
  assign fifo_empty = (occ == '0);
  assign push       = MemWrite & ~fifo_full;

  assign aw_hs     = cpu_mem_awvalid & cpu_mem_awready;
  assign w_hs      = cpu_mem_wvalid & cpu_mem_wready;
  assign aw_done_n = aw_done | aw_hs;
  assign w_done_n  = w_done | w_hs;
  assign pop       = head_vld & aw_done_n & w_done_n;

  assign drained = fifo_empty & ~head_vld & (ob_cnt == '0);

  // Reads wait for all writes to be answered; a concurrent write wins.
  assign cpu_mem_arvalid = MemRead & drained & ~MemWrite;
  assign cpu_mem_araddr  = cpu_mem_arvalid ? Address : 32'd0;
  assign Mem_Req_Ready   = push | (cpu_mem_arvalid & cpu_mem_arready);

  assign Read_data       = cpu_mem_rdata;
  assign Read_data_Valid = cpu_mem_rvalid;
  assign cpu_mem_rready  = Read_data_Ready;

  // Buffer payload storage; contents are only meaningful between push and pop.
  always_ff @(posedge cpu_clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= Address;
      fifo_data[wr_ptr] <= Write_data;
      fifo_strb[wr_ptr] <= Write_strb;
    end
  end

  // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge cpu_clk) begin
    if (cpu_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Head transfer: copy the oldest entry onto AW/W, retire each channel independently.
  always_ff @(posedge cpu_clk) begin
    if (cpu_reset) begin
      head_vld        <= 1'b0;
      aw_done         <= 1'b0;
      w_done          <= 1'b0;
      cpu_mem_awvalid <= 1'b0;
      cpu_mem_wvalid  <= 1'b0;
      cpu_mem_awaddr  <= 32'd0;
      cpu_mem_wdata   <= 32'd0;
      cpu_mem_wstrb   <= 4'd0;
    end else if (!head_vld) begin
      if (!fifo_empty) begin
        head_vld        <= 1'b1;
        cpu_mem_awvalid <= 1'b1;
        cpu_mem_wvalid  <= 1'b1;
        cpu_mem_awaddr  <= fifo_addr[rd_ptr];
        cpu_mem_wdata   <= fifo_data[rd_ptr];
        cpu_mem_wstrb   <= fifo_strb[rd_ptr];
      end
    end else begin
      if (aw_hs) cpu_mem_awvalid <= 1'b0;
      if (w_hs)  cpu_mem_wvalid  <= 1'b0;
      if (pop) begin
        head_vld <= 1'b0;
        aw_done  <= 1'b0;
        w_done   <= 1'b0;
      end else begin
        aw_done <= aw_done_n;
        w_done  <= w_done_n;
      end
    end
  end

  // Outstanding B responses: one per popped entry, retired by each bvalid.
  always_ff @(posedge cpu_clk) begin
    if (cpu_reset) begin
      ob_cnt <= '0;
    end else begin
      case ({pop, cpu_mem_bvalid})
        2'b10:   ob_cnt <= ob_cnt + OCC_W'(1);
        2'b01:   ob_cnt <= (ob_cnt != '0) ? ob_cnt - OCC_W'(1) : ob_cnt;
        default: ob_cnt <= ob_cnt;
      endcase
    end
  end

  // Sticky error flag for any non-OKAY write response.
  always_ff @(posedge cpu_clk) begin
    if (cpu_reset) begin
      wr_err <= 1'b0;
    end else if (cpu_mem_bvalid && (cpu_mem_bresp != 2'b00)) begin
      wr_err <= 1'b1;
    end
  end

`ifdef CPU_MEM_PERF_CNT_EN
  logic [CNT_W-1:0] full_cnt_q;
  logic [CNT_W-1:0] drain_cnt_q;

  // Stall counters: cycles a write is refused, cycles a read waits for the drain.
  always_ff @(posedge cpu_clk) begin
    if (cpu_reset) begin
      full_cnt_q  <= '0;
      drain_cnt_q <= '0;
    end else begin
      if (MemWrite && fifo_full)               full_cnt_q  <= full_cnt_q + CNT_W'(1);
      if (MemRead && !MemWrite && !drained)    drain_cnt_q <= drain_cnt_q + CNT_W'(1);
    end
  end

  assign wb_full_stall_cnt  = full_cnt_q;
  assign rd_drain_stall_cnt = drain_cnt_q;
`else
  assign wb_full_stall_cnt  = '0;
  assign rd_drain_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_mem_axi_wbuf.sv
// Directed bench for cpu_mem_axi_wbuf: posted writes, full stall, split AW/W
// handshakes, read-after-write ordering, error response and mid-flight reset.
module tb_cpu_mem_axi_wbuf;

  localparam int WB_DEPTH = 4;
  localparam int CNT_W    = 32;

  logic             cpu_clk = 1'b0;
  logic             cpu_reset;
  logic [31:0]      Address;
  logic             MemWrite;
  logic [31:0]      Write_data;
  logic [3:0]       Write_strb;
  logic             MemRead;
  logic             Mem_Req_Ready;
  logic [31:0]      Read_data;
  logic             Read_data_Valid;
  logic             Read_data_Ready;
  logic [31:0]      cpu_mem_araddr;
  logic             cpu_mem_arvalid;
  logic             cpu_mem_arready;
  logic [2:0]       cpu_mem_arsize;
  logic [1:0]       cpu_mem_arburst;
  logic [7:0]       cpu_mem_arlen;
  logic [31:0]      cpu_mem_rdata;
  logic             cpu_mem_rvalid;
  logic             cpu_mem_rlast;
  logic             cpu_mem_rready;
  logic [31:0]      cpu_mem_awaddr;
  logic             cpu_mem_awvalid;
  logic             cpu_mem_awready;
  logic [2:0]       cpu_mem_awsize;
  logic [1:0]       cpu_mem_awburst;
  logic [7:0]       cpu_mem_awlen;
  logic [31:0]      cpu_mem_wdata;
  logic [3:0]       cpu_mem_wstrb;
  logic             cpu_mem_wvalid;
  logic             cpu_mem_wlast;
  logic             cpu_mem_wready;
  logic             cpu_mem_bvalid;
  logic [1:0]       cpu_mem_bresp;
  logic             cpu_mem_bready;
  logic             wr_err;
  logic [CNT_W-1:0] wb_full_stall_cnt;
  logic [CNT_W-1:0] rd_drain_stall_cnt;

  cpu_mem_axi_wbuf #(.WB_DEPTH(WB_DEPTH), .CNT_W(CNT_W)) dut (
    .cpu_clk(cpu_clk), .cpu_reset(cpu_reset),
    .Address(Address), .MemWrite(MemWrite), .Write_data(Write_data),
    .Write_strb(Write_strb), .MemRead(MemRead), .Mem_Req_Ready(Mem_Req_Ready),
    .Read_data(Read_data), .Read_data_Valid(Read_data_Valid),
    .Read_data_Ready(Read_data_Ready),
    .cpu_mem_araddr(cpu_mem_araddr), .cpu_mem_arvalid(cpu_mem_arvalid),
    .cpu_mem_arready(cpu_mem_arready), .cpu_mem_arsize(cpu_mem_arsize),
    .cpu_mem_arburst(cpu_mem_arburst), .cpu_mem_arlen(cpu_mem_arlen),
    .cpu_mem_rdata(cpu_mem_rdata), .cpu_mem_rvalid(cpu_mem_rvalid),
    .cpu_mem_rlast(cpu_mem_rlast), .cpu_mem_rready(cpu_mem_rready),
    .cpu_mem_awaddr(cpu_mem_awaddr), .cpu_mem_awvalid(cpu_mem_awvalid),
    .cpu_mem_awready(cpu_mem_awready), .cpu_mem_awsize(cpu_mem_awsize),
    .cpu_mem_awburst(cpu_mem_awburst), .cpu_mem_awlen(cpu_mem_awlen),
    .cpu_mem_wdata(cpu_mem_wdata), .cpu_mem_wstrb(cpu_mem_wstrb),
    .cpu_mem_wvalid(cpu_mem_wvalid), .cpu_mem_wlast(cpu_mem_wlast),
    .cpu_mem_wready(cpu_mem_wready),
    .cpu_mem_bvalid(cpu_mem_bvalid), .cpu_mem_bresp(cpu_mem_bresp),
    .cpu_mem_bready(cpu_mem_bready),
    .wr_err(wr_err), .wb_full_stall_cnt(wb_full_stall_cnt),
    .rd_drain_stall_cnt(rd_drain_stall_cnt)
  );

  // clock / reset
  always #5 cpu_clk = ~cpu_clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // scoreboard: expected and observed AW addresses and W {strb,data} beats
  logic [35:0] exp_q[$];
  logic [35:0] got_q[$];
  logic [31:0] exp_aw_q[$];
  logic [31:0] got_aw_q[$];
  int          aw_cnt = 0;
  int          w_cnt  = 0;

  // B responder controls
  int          b_sent     = 0;
  int          b_timer    = 0;
  int          b_delay    = 0;
  logic [1:0]  b_resp_val = 2'b00;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // drive slot: just after the rising edge
  task automatic tick();
    @(posedge cpu_clk);
    #2;
  endtask

  // sample slot: falling edge, away from the active edge
  task automatic sample();
    @(negedge cpu_clk);
  endtask

  task automatic drive_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    MemWrite   = 1'b1;
    Address    = a;
    Write_data = d;
    Write_strb = s;
  endtask

  task automatic expect_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_aw_q.push_back(a);
    exp_q.push_back({s, d});
  endtask

  // wait until target beats have completed and been answered, then let it settle
  task automatic wait_writes(input int target, input string tag);
    int n = 0;
    while (!(aw_cnt >= target && w_cnt >= target && b_sent >= target) && n < 100) begin
      tick();
      n++;
    end
    repeat (2) tick();
    check({tag, "_drain_timeout"}, 64'(n < 100), 64'd1);
  endtask

  task automatic compare_beats(input string tag);
    check({tag, "_aw_count"}, 64'(got_aw_q.size()), 64'(exp_aw_q.size()));
    check({tag, "_w_count"},  64'(got_q.size()),    64'(exp_q.size()));
    while (exp_aw_q.size() > 0) begin
      logic [31:0] e;
      e = exp_aw_q.pop_front();
      if (got_aw_q.size() > 0) check({tag, "_awaddr"}, 64'(got_aw_q.pop_front()), 64'(e));
      else                     check({tag, "_awaddr_missing"}, 64'hx, 64'(e));
    end
    while (exp_q.size() > 0) begin
      logic [35:0] e;
      e = exp_q.pop_front();
      if (got_q.size() > 0) check({tag, "_wbeat"}, 64'(got_q.pop_front()), 64'(e));
      else                  check({tag, "_wbeat_missing"}, 64'hx, 64'(e));
    end
    got_aw_q.delete();
    got_q.delete();
  endtask

  // monitor: record handshakes that will complete at the next rising edge
  always @(negedge cpu_clk) begin
    if (cpu_reset === 1'b0) begin
      if (cpu_mem_awvalid && cpu_mem_awready) begin
        got_aw_q.push_back(cpu_mem_awaddr);
        aw_cnt++;
      end
      if (cpu_mem_wvalid && cpu_mem_wready) begin
        got_q.push_back({cpu_mem_wstrb, cpu_mem_wdata});
        w_cnt++;
      end
    end
  end

  // B responder: one response per completed AW+W pair, after b_delay cycles
  always @(posedge cpu_clk) begin
    #2;
    cpu_mem_bvalid = 1'b0;
    if (cpu_reset) begin
      b_timer = 0;
    end else if (b_sent < ((aw_cnt < w_cnt) ? aw_cnt : w_cnt)) begin
      if (b_timer >= b_delay) begin
        cpu_mem_bvalid = 1'b1;
        cpu_mem_bresp  = b_resp_val;
        b_sent++;
        b_timer = 0;
      end else begin
        b_timer++;
      end
    end else begin
      b_timer = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rdy_cnt;
    int n;
    int aw_base;
    int w_base;
    logic b_seen;

    cpu_reset       = 1'b1;
    Address         = 32'd0;
    MemWrite        = 1'b0;
    Write_data      = 32'd0;
    Write_strb      = 4'd0;
    MemRead         = 1'b0;
    Read_data_Ready = 1'b0;
    cpu_mem_arready = 1'b0;
    cpu_mem_rdata   = 32'd0;
    cpu_mem_rvalid  = 1'b0;
    cpu_mem_rlast   = 1'b0;
    cpu_mem_awready = 1'b0;
    cpu_mem_wready  = 1'b0;
    cpu_mem_bvalid  = 1'b0;
    cpu_mem_bresp   = 2'b00;

    // reset state
    repeat (2) tick();
    sample();
    check("rst_awvalid", 64'(cpu_mem_awvalid), 64'd0);
    check("rst_wvalid",  64'(cpu_mem_wvalid),  64'd0);
    check("rst_arvalid", 64'(cpu_mem_arvalid), 64'd0);
    check("rst_awaddr",  64'(cpu_mem_awaddr),  64'd0);
    check("rst_wdata",   64'(cpu_mem_wdata),   64'd0);
    check("rst_wr_err",  64'(wr_err),          64'd0);
    check("rst_full_cnt",  64'(wb_full_stall_cnt),  64'd0);
    check("rst_drain_cnt", 64'(rd_drain_stall_cnt), 64'd0);
    check("tie_awsize",  64'(cpu_mem_awsize),  64'd2);
    check("tie_arburst", 64'(cpu_mem_arburst), 64'd1);
    check("tie_bready",  64'(cpu_mem_bready),  64'd1);
    tick();
    cpu_reset = 1'b0;

    // 4 back-to-back writes, both readies high
    cpu_mem_awready = 1'b1;
    cpu_mem_wready  = 1'b1;
    rdy_cnt = 0;
    drive_write(32'h0000_1000, 32'hA0A0_0000, 4'hF); expect_write(32'h0000_1000, 32'hA0A0_0000, 4'hF);
    sample(); if (Mem_Req_Ready) rdy_cnt++; tick();
    drive_write(32'h0000_1004, 32'hA0A0_0001, 4'h3); expect_write(32'h0000_1004, 32'hA0A0_0001, 4'h3);
    sample(); if (Mem_Req_Ready) rdy_cnt++; tick();
    drive_write(32'h0000_1008, 32'hA0A0_0002, 4'hC); expect_write(32'h0000_1008, 32'hA0A0_0002, 4'hC);
    sample(); if (Mem_Req_Ready) rdy_cnt++; tick();
    drive_write(32'h0000_100C, 32'hA0A0_0003, 4'h1); expect_write(32'h0000_100C, 32'hA0A0_0003, 4'h1);
    sample(); if (Mem_Req_Ready) rdy_cnt++; tick();
    MemWrite = 1'b0;
    check("t1_ready_cycles", 64'(rdy_cnt), 64'd4);
    wait_writes(4, "t1");
    sample();
    check("t1_occ_zero", 64'(dut.occ), 64'd0);
    compare_beats("t1");
    tick();

    // 5 writes with awready low: the fifth stalls until the first pop
    cpu_mem_awready = 1'b0;
    cpu_mem_wready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_write(32'h0000_2000 + 32'(i * 4), 32'hB0B0_0000 + 32'(i), 4'hF);
      expect_write(32'h0000_2000 + 32'(i * 4), 32'hB0B0_0000 + 32'(i), 4'hF);
      sample();
      check("t2_accept", 64'(Mem_Req_Ready), 64'd1);
      tick();
    end
    drive_write(32'h0000_2010, 32'hB0B0_0004, 4'h5);
    expect_write(32'h0000_2010, 32'hB0B0_0004, 4'h5);
    sample(); check("t2_stall_a", 64'(Mem_Req_Ready), 64'd0); tick();
    sample(); check("t2_stall_b", 64'(Mem_Req_Ready), 64'd0); tick();
    sample(); check("t2_stall_c", 64'(Mem_Req_Ready), 64'd0); tick();
    cpu_mem_awready = 1'b1;
    sample(); check("t2_stall_pop_cycle", 64'(Mem_Req_Ready), 64'd0); tick();
    sample(); check("t2_accept_after_pop", 64'(Mem_Req_Ready), 64'd1); tick();
    MemWrite = 1'b0;
    wait_writes(9, "t2");
`ifdef CPU_MEM_PERF_CNT_EN
    check("t2_full_stall_cnt", 64'(wb_full_stall_cnt), 64'd4);
`else
    check("t2_full_stall_cnt", 64'(wb_full_stall_cnt), 64'd0);
`endif
    compare_beats("t2");

    // W accepted while AW is held off: one entry, popped only after AW
    cpu_mem_awready = 1'b0;
    cpu_mem_wready  = 1'b1;
    drive_write(32'h0000_3000, 32'hC0C0_0001, 4'hA);
    expect_write(32'h0000_3000, 32'hC0C0_0001, 4'hA);
    tick();
    MemWrite = 1'b0;
    n = 0;
    sample();
    while (!(cpu_mem_wvalid && cpu_mem_wready) && n < 20) begin
      tick();
      sample();
      n++;
    end
    check("t3_w_seen", 64'(n < 20), 64'd1);
    tick(); sample();
    check("t3_wvalid_dropped", 64'(cpu_mem_wvalid),  64'd0);
    check("t3_awvalid_held",   64'(cpu_mem_awvalid), 64'd1);
    check("t3_occ_before_aw",  64'(dut.occ),         64'd1);
    tick(); sample();
    check("t3_wvalid_still_low", 64'(cpu_mem_wvalid), 64'd0);
    check("t3_occ_wait",         64'(dut.occ),        64'd1);
    tick();
    cpu_mem_awready = 1'b1;
    sample();
    check("t3_occ_aw_cycle", 64'(dut.occ), 64'd1);
    tick(); sample();
    check("t3_occ_popped",   64'(dut.occ),         64'd0);
    check("t3_awvalid_done", 64'(cpu_mem_awvalid), 64'd0);
    tick();
    wait_writes(10, "t3");
    compare_beats("t3");

    // write 0x100 then read 0x100 with a delayed B
    b_delay         = 5;
    cpu_mem_arready = 1'b1;
    drive_write(32'h0000_0100, 32'h1234_5678, 4'hF);
    expect_write(32'h0000_0100, 32'h1234_5678, 4'hF);
    tick();
    MemWrite = 1'b0;
    MemRead  = 1'b1;
    Address  = 32'h0000_0100;
    sample();
    check("t4_arvalid_blocked", 64'(cpu_mem_arvalid), 64'd0);
    check("t4_araddr_idle",     64'(cpu_mem_araddr),  64'd0);
    check("t4_no_ready",        64'(Mem_Req_Ready),   64'd0);
    b_seen = 1'b0;
    n = 0;
    while (!cpu_mem_arvalid && n < 40) begin
      if (cpu_mem_bvalid) b_seen = 1'b1;
      tick();
      sample();
      n++;
    end
    check("t4_b_before_ar", 64'(b_seen),          64'd1);
    check("t4_arvalid",     64'(cpu_mem_arvalid), 64'd1);
    check("t4_araddr",      64'(cpu_mem_araddr),  64'h100);
    check("t4_rd_accept",   64'(Mem_Req_Ready),   64'd1);
`ifdef CPU_MEM_PERF_CNT_EN
    check("t4_drain_cnt_nonzero", 64'(rd_drain_stall_cnt != 0), 64'd1);
`else
    check("t4_drain_cnt_nonzero", 64'(rd_drain_stall_cnt), 64'd0);
`endif
    tick();
    MemRead         = 1'b0;
    cpu_mem_rdata   = 32'hDEAD_BEEF;
    cpu_mem_rvalid  = 1'b1;
    cpu_mem_rlast   = 1'b1;
    Read_data_Ready = 1'b1;
    sample();
    check("t4_read_data",  64'(Read_data),       64'hDEAD_BEEF);
    check("t4_read_valid", 64'(Read_data_Valid), 64'd1);
    check("t4_rready",     64'(cpu_mem_rready),  64'd1);
    check("t4_ar_idle",    64'(cpu_mem_arvalid), 64'd0);
    tick();
    cpu_mem_rvalid  = 1'b0;
    cpu_mem_rlast   = 1'b0;
    Read_data_Ready = 1'b0;
    sample();
    check("t4_rready_low", 64'(cpu_mem_rready), 64'd0);
    tick();
    b_delay = 0;
    wait_writes(11, "t4");
    compare_beats("t4");

    // error response plus write-over-read priority
    sample();
    check("t5_wr_err_clear", 64'(wr_err), 64'd0);
    tick();
    b_resp_val = 2'b10;
    drive_write(32'h0000_0500, 32'h5555_0001, 4'hF);
    expect_write(32'h0000_0500, 32'h5555_0001, 4'hF);
    MemRead = 1'b1;
    sample();
    check("t5_prio_no_ar", 64'(cpu_mem_arvalid), 64'd0);
    check("t5_prio_write", 64'(Mem_Req_Ready),   64'd1);
    tick();
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    wait_writes(12, "t5a");
    sample();
    check("t5_wr_err_set", 64'(wr_err), 64'd1);
    tick();
    b_resp_val = 2'b00;
    drive_write(32'h0000_0504, 32'h5555_0002, 4'hF);
    expect_write(32'h0000_0504, 32'h5555_0002, 4'hF);
    tick();
    MemWrite = 1'b0;
    wait_writes(13, "t5b");
    sample();
    check("t5_wr_err_held", 64'(wr_err), 64'd1);
    compare_beats("t5");
    tick();

    // reset with three buffered writes
    cpu_mem_awready = 1'b0;
    cpu_mem_wready  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_write(32'h0000_6000 + 32'(i * 4), 32'h6666_0000 + 32'(i), 4'hF);
      tick();
    end
    MemWrite = 1'b0;
    repeat (3) tick();
    sample();
    check("t6_awvalid_pending", 64'(cpu_mem_awvalid), 64'd1);
    check("t6_occ_three",       64'(dut.occ),         64'd3);
    tick();
    cpu_reset = 1'b1;
    tick();
    cpu_reset       = 1'b0;
    cpu_mem_awready = 1'b1;
    cpu_mem_wready  = 1'b1;
    MemRead         = 1'b1;
    Address         = 32'h0000_0200;
    aw_base         = aw_cnt;
    w_base          = w_cnt;
    sample();
    check("t6_awvalid_cleared", 64'(cpu_mem_awvalid), 64'd0);
    check("t6_wvalid_cleared",  64'(cpu_mem_wvalid),  64'd0);
    check("t6_wr_err_cleared",  64'(wr_err),          64'd0);
    check("t6_read_immediate",  64'(cpu_mem_arvalid), 64'd1);
    check("t6_read_addr",       64'(cpu_mem_araddr),  64'h200);
    check("t6_full_cnt_clr",    64'(wb_full_stall_cnt), 64'd0);
    repeat (5) tick();
    MemRead = 1'b0;
    sample();
    check("t6_no_aw_beats", 64'(aw_cnt - aw_base), 64'd0);
    check("t6_no_w_beats",  64'(w_cnt - w_base),   64'd0);
    check("t6_occ_zero",    64'(dut.occ),          64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
